// File: rtl/cmos_dvp_gen_if.sv
// DVP camera pad bundle: pixel clock, frame/line syncs and the 8-bit data byte.
interface cmos_dvp_gen_if;
  logic       cmos_pclk;
  logic       cmos_vsyn;
  logic       cmos_href;
  logic [7:0] cmos_data;

  modport master (output cmos_pclk, output cmos_vsyn, output cmos_href, output cmos_data);
  modport slave  (input  cmos_pclk, input  cmos_vsyn, input  cmos_href, input  cmos_data);
endinterface

// File: rtl/cmos_dvp_gen.sv
// Synthetic DVP source emitting RGB565 test frames, high byte first.
// Optional CMOS_DVP_GEN_FRAME_STAMP_EN: pixel (0,0) of each frame carries frame_cnt.
//
// state  | meaning
// IDLE   | outputs quiet, waiting for enable
// VSYNC  | VS_LINES lines with vsync high
// VBACK  | VB_LINES back-porch lines
// ACTIVE | V_ACTIVE lines with href over the first 2*H_ACTIVE slots
// VFRONT | VF_LINES front-porch lines, then next frame or IDLE
module cmos_dvp_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 3,
  parameter int VB_LINES = 17,
  parameter int VF_LINES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  cmos_dvp_gen_if.master dvp,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int L  = 2 * H_ACTIVE + H_BLANK;
  localparam int SW = $clog2(L);
  localparam int LW = $clog2(VS_LINES + VB_LINES + V_ACTIVE + VF_LINES + 1);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int BW = $clog2(H_ACTIVE / 8 + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBACK  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_VFRONT = 3'd4;

  logic          ph;
  logic [2:0]    st, nst;
  logic [SW-1:0] slot, nslot;
  logic [LW-1:0] ln, nln;
  logic [XW-1:0] x, nx;
  logic [BW-1:0] bcnt, nbcnt;
  logic [2:0]    bar, nbar;
  logic [1:0]    pat, npat;
  logic [15:0]   stamp, nstamp, nfc;
  logic          vsyn_q, href_q;
  logic [7:0]    data_q;

  int            st_lines;
  logic          nhref;
  logic [7:0]    ndata, x8, y8;
  logic [15:0]   pix;

  always_comb begin
    case (st)
      S_VSYNC:  st_lines = VS_LINES;
      S_VBACK:  st_lines = VB_LINES;
      S_ACTIVE: st_lines = V_ACTIVE;
      S_VFRONT: st_lines = VF_LINES;
      default:  st_lines = 1;
    endcase
  end

  // Counters here describe the slot about to be presented on the next falling pclk.
  always_comb begin
    nst    = st;
    nslot  = slot;
    nln    = ln;
    npat   = pat;
    nstamp = stamp;
    nfc    = frame_cnt;
    if (st == S_IDLE) begin
      if (enable) begin
        nst    = S_VSYNC;
        nslot  = '0;
        nln    = '0;
        npat   = pattern_sel;
        nstamp = frame_cnt;
      end
    end else if (slot == SW'(L - 1)) begin
      nslot = '0;
      if (ln == LW'(st_lines - 1)) begin
        nln = '0;
        case (st)
          S_VSYNC:  nst = S_VBACK;
          S_VBACK:  nst = S_ACTIVE;
          S_ACTIVE: nst = S_VFRONT;
          default: begin
            nfc = frame_cnt + 16'd1;
            if (enable) begin
              nst    = S_VSYNC;
              npat   = pattern_sel;
              nstamp = nfc;
            end else begin
              nst = S_IDLE;
            end
          end
        endcase
      end else begin
        nln = ln + LW'(1);
      end
    end else begin
      nslot = slot + SW'(1);
    end
  end

  // Pixel column and colour-bar index advance together, once per byte pair.
  always_comb begin
    nx    = x;
    nbcnt = bcnt;
    nbar  = bar;
    if (nslot == '0) begin
      nx    = '0;
      nbcnt = '0;
      nbar  = '0;
    end else if (!nslot[0] && (nslot < SW'(2 * H_ACTIVE))) begin
      nx = x + XW'(1);
      if (bcnt == BW'(H_ACTIVE / 8 - 1)) begin
        nbcnt = '0;
        nbar  = bar + 3'd1;
      end else begin
        nbcnt = bcnt + BW'(1);
      end
    end
  end

  always_comb begin
    x8 = 8'(nx);
    y8 = 8'(nln);
    case (npat)
      2'd0: begin
        case (nbar)
          3'd0:    pix = 16'hFFFF;
          3'd1:    pix = 16'hFFE0;
          3'd2:    pix = 16'h07FF;
          3'd3:    pix = 16'h07E0;
          3'd4:    pix = 16'hF81F;
          3'd5:    pix = 16'hF800;
          3'd6:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd1:    pix = {y8, x8};
      2'd2:    pix = nstamp;
      default: pix = (x8[4] ^ y8[4]) ? 16'hFFFF : 16'h0000;
    endcase
`ifdef CMOS_DVP_GEN_FRAME_STAMP_EN
    if ((nx == '0) && (nln == '0)) pix = nstamp;
`endif
    nhref = (nst == S_ACTIVE) && (nslot < SW'(2 * H_ACTIVE));
    ndata = nhref ? (nslot[0] ? pix[7:0] : pix[15:8]) : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph        <= 1'b0;
      st        <= S_IDLE;
      slot      <= '0;
      ln        <= '0;
      x         <= '0;
      bcnt      <= '0;
      bar       <= '0;
      pat       <= '0;
      stamp     <= '0;
      frame_cnt <= '0;
      busy      <= 1'b0;
      vsyn_q    <= 1'b0;
      href_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      ph <= ~ph;
      if (ph) begin
        st        <= nst;
        slot      <= nslot;
        ln        <= nln;
        x         <= nx;
        bcnt      <= nbcnt;
        bar       <= nbar;
        pat       <= npat;
        stamp     <= nstamp;
        frame_cnt <= nfc;
        busy      <= (nst != S_IDLE);
        vsyn_q    <= (nst == S_VSYNC);
        href_q    <= nhref;
        data_q    <= ndata;
      end
    end
  end

  assign dvp.cmos_pclk = ph;
  assign dvp.cmos_vsyn = vsyn_q;
  assign dvp.cmos_href = href_q;
  assign dvp.cmos_data = data_q;

endmodule

// File: tb/tb_cmos_dvp_gen.sv
// Scoreboard bench for cmos_dvp_gen: a frame-level model queues expected slots, a monitor checks them.
module tb_cmos_dvp_gen;
  localparam int H  = 16;
  localparam int V  = 4;
  localparam int HB = 8;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int L  = 2 * H + HB;
  localparam int NL = VS + VB + V + VF;

  typedef struct packed {
    logic        vs;
    logic        hr;
    logic [7:0]  d;
    logic        bz;
    logic [15:0] fc;
  } slot_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] frame_cnt;
  logic        busy;
  logic        tb_ph;

  cmos_dvp_gen_if dvp();

  cmos_dvp_gen #(
    .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB),
    .VS_LINES(VS), .VB_LINES(VB), .VF_LINES(VF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .dvp(dvp), .frame_cnt(frame_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_ph <= 1'b0;
    else        tb_ph <= ~tb_ph;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  slot_t       exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          started = 0;
  logic [15:0] fc_model = 16'd0;

  task automatic push_frame(input logic [1:0] p, input logic [15:0] stmp);
    for (int l = 0; l < NL; l++) begin
      for (int s = 0; s < L; s++) begin
        slot_t       e;
        int          x;
        int          y;
        bit          act;
        logic [15:0] pix;
        x   = s / 2;
        y   = l - VS - VB;
        act = (l >= VS + VB) && (l < VS + VB + V);
        case (p)
          2'd0:    pix = bars[x / (H / 8)];
          2'd1:    pix = {8'(y), 8'(x)};
          2'd2:    pix = stmp;
          default: pix = ((((x / 16) % 2) != ((y / 16) % 2))) ? 16'hFFFF : 16'h0000;
        endcase
`ifdef CMOS_DVP_GEN_FRAME_STAMP_EN
        if (x == 0 && y == 0) pix = stmp;
`endif
        e.vs = (l < VS);
        e.hr = act && (s < 2 * H);
        e.d  = e.hr ? ((s % 2 == 1) ? pix[7:0] : pix[15:8]) : 8'h00;
        e.bz = 1'b1;
        e.fc = stmp;
        exp_q.push_back(e);
      end
    end
  endtask

  // Model: just before each falling pclk, decide what the next slot must be.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      fc_model = 16'd0;
      started  = 0;
    end else if (tb_ph) begin
      if (exp_q.size() == 0) begin
        if (enable) begin
          push_frame(pattern_sel, fc_model);
          fc_model = fc_model + 16'd1;
        end else begin
          exp_q.push_back('{vs: 1'b0, hr: 1'b0, d: 8'h00, bz: 1'b0, fc: fc_model});
        end
      end
      started = 1;
    end
  end

  // Monitor: mid-slot, compare the presented slot with the queue head.
  always @(negedge clk) begin
    slot_t a;
    slot_t e;
    a = {dvp.cmos_vsyn, dvp.cmos_href, dvp.cmos_data, busy, frame_cnt};
    if (!rst_n) begin
      vectors++;
      if (a != '0 || dvp.cmos_pclk !== 1'b0) begin
        miscompares++;
        $display("FAIL in_reset t=%0t got pclk=%b vs=%b hr=%b d=%h busy=%b fc=%0d want all 0",
                 $time, dvp.cmos_pclk, a.vs, a.hr, a.d, a.bz, a.fc);
      end
    end else begin
      vectors++;
      if (dvp.cmos_pclk !== tb_ph) begin
        miscompares++;
        $display("FAIL pclk t=%0t got %b want %b", $time, dvp.cmos_pclk, tb_ph);
      end
      if (!tb_ph) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          vectors++;
          if (a !== e) begin
            miscompares++;
            $display("FAIL slot t=%0t got vs=%b hr=%b d=%h busy=%b fc=%0d want vs=%b hr=%b d=%h busy=%b fc=%0d",
                     $time, a.vs, a.hr, a.d, a.bz, a.fc, e.vs, e.hr, e.d, e.bz, e.fc);
          end
        end else if (started) begin
          vectors++;
          miscompares++;
          $display("FAIL underflow t=%0t got empty queue want an expected slot", $time);
        end
      end
    end
  end

  task automatic slot_mid();
    do @(negedge clk); while (tb_ph);
  endtask

  task automatic wait_href_rise();
    int n = 0;
    while (dvp.cmos_href && n <= 3000) begin @(negedge clk); n++; end
    while (!dvp.cmos_href && n <= 3000) begin @(negedge clk); n++; end
    if (n > 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL href_timeout t=%0t got no href rise want one within 3000 clk", $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (dvp.cmos_pclk !== 1'b0 || dvp.cmos_vsyn !== 1'b0 || dvp.cmos_href !== 1'b0 ||
        dvp.cmos_data !== 8'h00 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_immediate t=%0t got pclk=%b vs=%b hr=%b d=%h busy=%b fc=%0d want all 0",
               $time, dvp.cmos_pclk, dvp.cmos_vsyn, dvp.cmos_href, dvp.cmos_data, busy, frame_cnt);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    pattern_sel = 2'd1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (200) @(negedge clk);

    slot_mid(); pattern_sel = 2'd1; enable = 1'b1;
    repeat (560) @(negedge clk);
    slot_mid(); pattern_sel = 2'd0;
    repeat (560) @(negedge clk);
    slot_mid(); pattern_sel = 2'd2;
    repeat (3 * 560) @(negedge clk);
    slot_mid(); pattern_sel = 2'd3;
    repeat (1120) @(negedge clk);

    // drop enable during the second active line
    wait_href_rise();
    wait_href_rise();
    slot_mid(); enable = 1'b0;
    repeat (800) @(negedge clk);

    slot_mid(); enable = 1'b1; pattern_sel = 2'd1;
    wait_href_rise();
    repeat (5) @(negedge clk);
    do_reset();
    repeat (700) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      slot_mid();
      enable      = ($urandom_range(0, 3) != 0);
      pattern_sel = 2'($urandom_range(0, 3));
      repeat ($urandom_range(20, 900)) @(negedge clk);
      if ($urandom_range(0, 7) == 0) do_reset();
    end

    slot_mid(); enable = 1'b0;
    repeat (800) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
